// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and parameter limits for the UART receiver
package uart_pkg;
  localparam int UART_MIN_CLKS_PER_BIT = 4;
  localparam int UART_MIN_DATA_BITS = 5;
  localparam int UART_MAX_DATA_BITS = 9;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, ERR_WAIT} uart_rx_state_t;
endpackage

// File: rtl/uart_rx_sipo.sv
// sipo: serial-in parallel-out register shifting in at the MSB, reset value R
module sipo #(
  parameter int N = 8,
  parameter int R = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_shift,
  input  logic         i_data,
  output logic [N-1:0] o_data
);
  // new bit enters at the top so the first bit received ends up at bit 0
  always_ff @(posedge i_clk)
    if (i_rst) o_data <= N'(R);
    else if (i_shift) o_data <= {i_data, o_data[N-1:1]};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 1-start/N-data/1-stop receiver with valid/ready output; optional parity via UART_RX_PARITY_EN
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun
`ifdef UART_RX_PARITY_EN
  ,output logic                o_parity_err
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
  localparam uart_rx_state_t AFTER_DATA = STOP;
`endif
  if (CLKS_PER_BIT < UART_MIN_CLKS_PER_BIT) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be >= %0d", UART_MIN_CLKS_PER_BIT);
  end
  if (DATA_BITS < UART_MIN_DATA_BITS || DATA_BITS > UART_MAX_DATA_BITS) begin : g_bad_db
    $error("uart_rx: DATA_BITS must be in %0d..%0d", UART_MIN_DATA_BITS, UART_MAX_DATA_BITS);
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_rx: PARITY_ODD must be 0 or 1");
  end
  logic rx_m, rx_s;
  uart_rx_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_BITS-1:0] word;
  logic tick, half, commit, stop_bad, word_ok;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign commit = state == STOP && tick && rx_s;
  assign stop_bad = state == STOP && tick && !rx_s;
  assign o_busy = state != IDLE;
  // two-flop synchroniser for the asynchronous line, idles high
  always_ff @(posedge i_clk)
    if (i_rst) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {i_rx, rx_m};
  // frame sequencing: start validation at mid-bit, then one bit time per step
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (!rx_s) state_n = START;
      START:    if (half) state_n = rx_s ? IDLE : DATA;
      DATA:     if (tick && bit_idx == BW'(DATA_BITS - 1)) state_n = AFTER_DATA;
      PARITY:   if (tick) state_n = STOP;
      STOP:     if (tick) state_n = rx_s ? IDLE : ERR_WAIT;
      ERR_WAIT: if (rx_s) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // state, baud counter (restarts on each state change and each tick) and bit index
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || tick || state == IDLE) ? '0 : cnt + 1'b1;
      bit_idx <= state != DATA ? '0 : tick ? bit_idx + 1'b1 : bit_idx;
    end
  sipo #(.N(DATA_BITS), .R(0)) u_sipo (
    .i_clk  (i_clk),
    .i_rst  (i_rst || (state == IDLE && !rx_s)),
    .i_shift(state == DATA && tick),
    .i_data (rx_s),
    .o_data (word)
  );
`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign word_ok = !par_bad;
  // parity check result, held until the stop-bit commit consumes it
  always_ff @(posedge i_clk)
    if (i_rst) par_bad <= 1'b0;
    else if (state == PARITY && tick) par_bad <= rx_s != ((^word) ^ (PARITY_ODD != 0));
  // parity error pulse coincides with the would-be commit
  always_ff @(posedge i_clk)
    if (i_rst) o_parity_err <= 1'b0;
    else o_parity_err <= commit && par_bad;
`else
  assign word_ok = 1'b1;
`endif
  // output holding register: accept a word if empty or being drained, else flag overrun
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_data <= '0;
      o_valid <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_frame_err <= stop_bad;
      o_overrun <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (commit && word_ok) begin
        if (!o_valid || i_ready) begin
          o_data <= word;
          o_valid <= 1'b1;
        end else o_overrun <= 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx (8N1, 16 clocks per bit)
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int DB = 8;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b1;
  logic [DB-1:0] data;
  logic valid, busy, ferr, ovr;
  int checks = 0, errors = 0, cyc = 0, nvalid = 0;
  int n_ferr = 0, n_ovr = 0, exp_ferr = 0, exp_ovr = 0;
  int first_valid = -1;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] held;
  logic held_v = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx), .i_ready(ready), .o_data(data),
    .o_valid(valid), .o_busy(busy), .o_frame_err(ferr), .o_overrun(ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every handshake, counts flag pulses
  always @(negedge clk) begin
    cyc++;
    if (rst) held_v = 1'b0;
    else begin
      if (ferr) n_ferr++;
      if (ovr) n_ovr++;
      if (valid) nvalid++;
      if (valid && first_valid < 0) first_valid = cyc;
      if (held_v && valid) check("data_stable", data, held);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_word: got %0h expected no word", data);
        end else check("word", data, exp_q.pop_front());
      end
      held_v = valid && !ready;
      held = data;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int clks);
    rx = b;
    cycles(clks);
  endtask

  // reference outcome decided from line-level rules before the frame is driven
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_ok, input int stop_clks);
    if (!stop_ok) exp_ferr++;
    else if (!ready && exp_q.size() > 0) exp_ovr++;
    else exp_q.push_back(d);
    send_bit(1'b0, CPB);
    for (int i = 0; i < DB; i++) send_bit(d[i], CPB);
    if (stop_ok) send_bit(1'b1, stop_clks);
    else begin
      send_bit(1'b0, 3 * CPB);
      check("err_wait_busy", busy, 1);
      send_bit(1'b1, 6);
      check("err_wait_exit", busy, 0);
    end
  endtask

  initial begin
    int t0, nv0;
    logic [DB-1:0] d;
    cycles(5);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", ovr, 0);
    rst = 1'b0;
    cycles(4);
    // single frame, immediate consumer
    t0 = cyc;
    nv0 = nvalid;
    send_frame(8'hA5, 1'b1, CPB);
    check("latency_window", (first_valid - t0 >= 150 && first_valid - t0 <= 162), 1);
    check("valid_one_cycle", nvalid - nv0, 1);
    // short low glitch must be rejected
    nv0 = nvalid;
    send_bit(1'b0, 4);
    rx = 1'b1;
    for (int i = 0; i < 12 && busy; i++) cycles(1);
    check("glitch_idle", busy, 0);
    check("glitch_no_valid", nvalid - nv0, 0);
    // framing error with line held low
    send_frame(8'h3C, 1'b0, CPB);
    check("ferr_count", n_ferr, exp_ferr);
    // back-to-back with stalled consumer
    ready = 1'b0;
    send_frame(8'h11, 1'b1, CPB);
    send_frame(8'h22, 1'b1, CPB);
    cycles(20);
    check("held_data", data, 8'h11);
    check("held_valid", valid, 1);
    check("ovr_count", n_ovr, exp_ovr);
    ready = 1'b1;
    cycles(2);
    check("valid_cleared", valid, 0);
    // reset in the middle of data bit 4
    d = 8'h5A;
    send_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bit(d[i], CPB);
    send_bit(d[4], 8);
    rst = 1'b1;
    rx = 1'b1;
    cycles(3);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    check("midrst_data", data, 0);
    rst = 1'b0;
    cycles(4);
    send_frame(8'h5A, 1'b1, CPB);
    // randomized traffic: data, stop validity, consumer readiness, stop length
    for (int k = 0; k < 24; k++) begin
      ready = 1'($urandom_range(0, 1));
      send_frame(8'($urandom), $urandom_range(0, 5) != 0, $urandom_range(CPB / 2 + 4, CPB));
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 40));
    end
    ready = 1'b1;
    cycles(40);
    check("queue_drained", exp_q.size(), 0);
    check("final_ferr", n_ferr, exp_ferr);
    check("final_ovr", n_ovr, exp_ovr);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
